// File: rtl/snake_pkg.sv
// -----------------------------------------------------------------------------
// snake_pkg
// Shared definitions for the snake game datapath: game-state and direction
// encodings, grid geometry and the snake start position. The game-state
// encodings are also used by the food generator and the state controller.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
package snake_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'b00,
        ST_PAUSE = 2'b01,
        ST_INIT  = 2'b10,
        ST_OVER  = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    // Columns 0 and GRID_W-1, rows 0 and GRID_H-1 are wall.
    localparam int GRID_W  = 32;
    localparam int GRID_H  = 24;

    // Head position after reset / INIT; the body trails to the left of it.
    localparam int START_X = 15;
    localparam int START_Y = 11;

    // Direction that would turn the snake back onto its own neck.
    function automatic dir_e reverse_dir(input dir_e d);
        case (d)
            DIR_UP:   return DIR_DOWN;
            DIR_DOWN: return DIR_UP;
            DIR_LEFT: return DIR_RIGHT;
            default:  return DIR_LEFT;
        endcase
    endfunction

endpackage

// File: rtl/snake_move_hit_cmp.sv
// -----------------------------------------------------------------------------
// snake_hit_cmp
// Compares one grid point against the live segments of the snake body.
//   pt_x, pt_y    point under test
//   seg_x, seg_y  segment register file, index 0 is the head
//   length        live segment count (indices 0..length-1 are live)
//   skip_head     ignore index 0 (used when the point is the new head itself)
//   exclude_tail  ignore index length-1 (tail vacates on a non-growing step)
//   hit           1 when any considered live segment sits on the point
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module snake_hit_cmp #(
    parameter int MAX_LEN = 16
) (
    input  logic [4:0] pt_x,
    input  logic [4:0] pt_y,
    input  logic [4:0] seg_x [MAX_LEN],
    input  logic [4:0] seg_y [MAX_LEN],
    input  logic [4:0] length,
    input  logic       skip_head,
    input  logic       exclude_tail,
    output logic       hit
);

    // NOTE: hit is given a default before the loop so no path leaves it
    // unassigned; without it always_comb would infer a latch.
    always_comb begin
        hit = 1'b0;
        for (int j = 0; j < MAX_LEN; j++) begin
            if ((5'(j) < length) &&
                !(skip_head && (j == 0)) &&
                !(exclude_tail && (5'(j) == length - 5'd1)) &&
                (seg_x[j] == pt_x) && (seg_y[j] == pt_y)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_move.sv
// -----------------------------------------------------------------------------
// snake_move
// Snake body engine: holds the segment coordinates, steps them on each
// movement tick, flags food consumption and wall/self collisions, and answers
// per-cell body queries for the renderer.
//   clk, rst            clock, synchronous active-high reset
//   game_state          PLAY / PAUSE / INIT / OVER (snake_pkg encodings)
//   move_tick           one-cycle step strobe
//   dir_in              requested direction
//   food_x, food_y      current food cell
//   get_food            one-cycle pulse after the head moves onto the food
//   crash               one-cycle pulse after a wall or self collision
//   head_x, head_y      head cell
//   length              live segment count
//   query_x, query_y    render query cell
//   query_hit           combinational: a live segment occupies the query cell
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module snake_move
    import snake_pkg::*;
#(
    parameter int MAX_LEN  = 16,
    parameter int INIT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] game_state,
    input  logic       move_tick,
    input  logic [1:0] dir_in,
    input  logic [4:0] food_x,
    input  logic [4:0] food_y,
    output logic       get_food,
    output logic       crash,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [4:0] length,
    input  logic [4:0] query_x,
    input  logic [4:0] query_y,
    output logic       query_hit
);

    logic [4:0] seg_x [MAX_LEN];
    logic [4:0] seg_y [MAX_LEN];
    dir_e       cur_dir;
    dir_e       last_step_dir;

    logic [4:0] nh_x;
    logic [4:0] nh_y;
    logic       wall_hit;
    logic       self_hit;
    logic       grow;

    game_state_e state;
    assign state = game_state_e'(game_state);

    // Candidate next head. No wrap handling: a wall cell is reached first.
    always_comb begin
        nh_x = seg_x[0];
        nh_y = seg_y[0];
        case (cur_dir)
            DIR_UP:    nh_y = seg_y[0] - 5'd1;
            DIR_DOWN:  nh_y = seg_y[0] + 5'd1;
            DIR_LEFT:  nh_x = seg_x[0] - 5'd1;
            default:   nh_x = seg_x[0] + 5'd1;
        endcase
    end

    assign wall_hit = (nh_x == 5'd0) || (nh_x == 5'(GRID_W - 1)) ||
                      (nh_y == 5'd0) || (nh_y == 5'(GRID_H - 1));
    assign grow     = (nh_x == food_x) && (nh_y == food_y);

    // The tail only counts as an obstacle when the snake grows this step;
    // otherwise it moves out of the way in the same step.
    snake_hit_cmp #(.MAX_LEN(MAX_LEN)) u_self_cmp (
        .pt_x         (nh_x),
        .pt_y         (nh_y),
        .seg_x        (seg_x),
        .seg_y        (seg_y),
        .length       (length),
        .skip_head    (1'b1),
        .exclude_tail (!grow),
        .hit          (self_hit)
    );

    snake_hit_cmp #(.MAX_LEN(MAX_LEN)) u_query_cmp (
        .pt_x         (query_x),
        .pt_y         (query_y),
        .seg_x        (seg_x),
        .seg_y        (seg_y),
        .length       (length),
        .skip_head    (1'b0),
        .exclude_tail (1'b0),
        .hit          (query_hit)
    );

    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values; the shift loop depends on this.
    always_ff @(posedge clk) begin
        if (rst || (state == ST_INIT)) begin
            // NOTE: the whole segment file is loaded here, not just the live
            // part, because the start layout is a defined game position.
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= 5'(START_X - i);
                seg_y[i] <= 5'(START_Y);
            end
            length        <= 5'(INIT_LEN);
            cur_dir       <= DIR_RIGHT;
            last_step_dir <= DIR_RIGHT;
            get_food      <= 1'b0;
            crash         <= 1'b0;
        end else begin
            get_food <= 1'b0;
            crash    <= 1'b0;
            if (state == ST_PLAY) begin
                // Compared against the last committed step, so two presses
                // between ticks cannot add up to a 180-degree turn.
                if (dir_e'(dir_in) != reverse_dir(last_step_dir)) begin
                    cur_dir <= dir_e'(dir_in);
                end
                if (move_tick) begin
                    if (wall_hit || self_hit) begin
                        crash <= 1'b1;
                    end else begin
                        for (int i = MAX_LEN - 1; i >= 1; i--) begin
                            seg_x[i] <= seg_x[i-1];
                            seg_y[i] <= seg_y[i-1];
                        end
                        seg_x[0]      <= nh_x;
                        seg_y[0]      <= nh_y;
                        last_step_dir <= cur_dir;
                        if (grow) begin
                            get_food <= 1'b1;
                            // At full length the shift simply drops the tail.
                            if (length != 5'(MAX_LEN)) begin
                                length <= length + 5'd1;
                            end
                        end
                    end
                end
            end
        end
    end

    assign head_x = seg_x[0];
    assign head_y = seg_y[0];

endmodule

// File: tb/tb_snake_move.sv
// -----------------------------------------------------------------------------
// tb_snake_move
// Self-checking bench for snake_move. A queue-based model of the snake body
// (front = head) predicts head, length, pulses and query answers each cycle.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_snake_move;
    import snake_pkg::*;

    localparam int MAX_LEN  = 16;
    localparam int INIT_LEN = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] game_state;
    logic       move_tick;
    logic [1:0] dir_in;
    logic [4:0] food_x, food_y;
    logic       get_food, crash;
    logic [4:0] head_x, head_y, length;
    logic [4:0] query_x, query_y;
    logic       query_hit;

    always #5 clk = ~clk;

    snake_move #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .game_state (game_state),
        .move_tick  (move_tick),
        .dir_in     (dir_in),
        .food_x     (food_x),
        .food_y     (food_y),
        .get_food   (get_food),
        .crash      (crash),
        .head_x     (head_x),
        .head_y     (head_y),
        .length     (length),
        .query_x    (query_x),
        .query_y    (query_y),
        .query_hit  (query_hit)
    );

    // Reference model: body[0] is the head, each entry is {x, y}.
    logic [9:0] body [$];
    logic [1:0] m_cur, m_last;
    logic       e_food, e_crash;
    int         vectors = 0;
    int         miscompares = 0;

    function automatic logic [1:0] opposite(input logic [1:0] d);
        if (d == DIR_UP)   return DIR_DOWN;
        if (d == DIR_DOWN) return DIR_UP;
        if (d == DIR_LEFT) return DIR_RIGHT;
        return DIR_LEFT;
    endfunction

    function automatic logic on_body(input int x, input int y);
        for (int j = 0; j < body.size(); j++)
            if (body[j] == {5'(x), 5'(y)}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_load();
        body.delete();
        for (int i = 0; i < INIT_LEN; i++) body.push_back({5'(START_X - i), 5'(START_Y)});
        m_cur  = DIR_RIGHT;
        m_last = DIR_RIGHT;
    endtask

    // One clock cycle: drive inputs, advance the model, check outputs.
    task automatic cyc(input logic r, input logic [1:0] st, input logic t,
                       input logic [1:0] d, input logic [4:0] fx, input logic [4:0] fy);
        int hx, hy, qi;
        logic grow, hit;
        logic [1:0] last_old;
        rst = r; game_state = st; move_tick = t; dir_in = d; food_x = fx; food_y = fy;
        e_food = 1'b0;
        e_crash = 1'b0;
        if (r || st == ST_INIT) begin
            model_load();
        end else if (st == ST_PLAY) begin
            last_old = m_last;
            if (t) begin
                hx = int'(body[0][9:5]);
                hy = int'(body[0][4:0]);
                if (m_cur == DIR_UP)         hy = hy - 1;
                else if (m_cur == DIR_DOWN)  hy = hy + 1;
                else if (m_cur == DIR_LEFT)  hx = hx - 1;
                else                         hx = hx + 1;
                grow = (hx == int'(fx)) && (hy == int'(fy));
                hit  = (hx <= 0) || (hx >= GRID_W - 1) || (hy <= 0) || (hy >= GRID_H - 1);
                for (int j = 1; j < body.size(); j++)
                    if (!(j == body.size() - 1 && !grow) && body[j] == {5'(hx), 5'(hy)}) hit = 1'b1;
                if (hit) begin
                    e_crash = 1'b1;
                end else begin
                    body.push_front({5'(hx), 5'(hy)});
                    if (!grow || body.size() > MAX_LEN) void'(body.pop_back());
                    m_last = m_cur;
                    e_food = grow;
                end
            end
            if (d != opposite(last_old)) m_cur = d;
        end
        @(posedge clk);
        #1;
        check("head_x", head_x, body[0][9:5]);
        check("head_y", head_y, body[0][4:0]);
        check("length", length, body.size());
        check("get_food", get_food, e_food);
        check("crash", crash, e_crash);
        if ($urandom_range(0, 1) == 0) begin
            qi = $urandom_range(0, body.size() - 1);
            query_x = body[qi][9:5];
            query_y = body[qi][4:0];
        end else begin
            query_x = 5'($urandom_range(0, GRID_W - 1));
            query_y = 5'($urandom_range(0, GRID_H - 1));
        end
        #1;
        check("query_hit", query_hit, on_body(query_x, query_y));
    endtask

    task automatic q_at(input string tag, input int x, input int y, input logic exp);
        query_x = 5'(x);
        query_y = 5'(y);
        #1;
        check(tag, query_hit, exp);
    endtask

    initial begin
        logic       r, t;
        logic [1:0] st, rd;
        logic [4:0] fx, fy;
        int         since_tick, over_cnt;

        query_x = '0; query_y = '0;
        model_load();

        // Reset state.
        cyc(1, ST_PLAY, 0, DIR_RIGHT, 17, 11);
        check("rst_head_x", head_x, 15);
        check("rst_head_y", head_y, 11);
        check("rst_len", length, 3);
        check("rst_food", get_food, 0);
        check("rst_crash", crash, 0);
        q_at("rst_seg1", 14, 11, 1);
        q_at("rst_seg2", 13, 11, 1);
        q_at("rst_beyond", 12, 11, 0);

        // Eat food two cells ahead.
        cyc(0, ST_PLAY, 1, DIR_RIGHT, 17, 11);
        check("eat_t1_x", head_x, 16);
        check("eat_t1_food", get_food, 0);
        cyc(0, ST_PLAY, 0, DIR_RIGHT, 17, 11);
        cyc(0, ST_PLAY, 1, DIR_RIGHT, 17, 11);
        check("eat_t2_x", head_x, 17);
        check("eat_t2_food", get_food, 1);
        check("eat_t2_len", length, 4);
        cyc(0, ST_PLAY, 0, DIR_RIGHT, 1, 1);
        check("eat_pulse_end", get_food, 0);

        // Tail chase: up, left, down lands on the cell the tail vacates.
        cyc(0, ST_PLAY, 0, DIR_UP, 1, 1);
        cyc(0, ST_PLAY, 1, DIR_UP, 1, 1);
        cyc(0, ST_PLAY, 0, DIR_LEFT, 1, 1);
        cyc(0, ST_PLAY, 1, DIR_LEFT, 1, 1);
        cyc(0, ST_PLAY, 0, DIR_DOWN, 1, 1);
        cyc(0, ST_PLAY, 1, DIR_DOWN, 1, 1);
        check("chase_crash", crash, 0);
        check("chase_y", head_y, 11);
        // Same move onto the tail, but growing there: collision.
        cyc(0, ST_PLAY, 0, DIR_RIGHT, 17, 11);
        cyc(0, ST_PLAY, 1, DIR_RIGHT, 17, 11);
        check("grow_tail_crash", crash, 1);
        check("grow_tail_x", head_x, 16);
        check("grow_tail_len", length, 4);
        cyc(0, ST_OVER, 0, DIR_RIGHT, 1, 1);
        check("crash_pulse_end", crash, 0);

        // INIT with a simultaneous tick: full reload.
        cyc(0, ST_INIT, 1, DIR_UP, 1, 1);
        check("init_x", head_x, 15);
        check("init_len", length, 3);

        // Reversal ignored; then up+left between ticks -> only up.
        cyc(0, ST_PLAY, 0, DIR_LEFT, 1, 1);
        cyc(0, ST_PLAY, 1, DIR_LEFT, 1, 1);
        check("rev_x", head_x, 16);
        cyc(0, ST_PLAY, 0, DIR_UP, 1, 1);
        cyc(0, ST_PLAY, 0, DIR_LEFT, 1, 1);
        cyc(0, ST_PLAY, 1, DIR_LEFT, 1, 1);
        check("upleft_x", head_x, 16);
        check("upleft_y", head_y, 10);

        // Run into the right wall.
        cyc(0, ST_INIT, 0, DIR_RIGHT, 1, 1);
        for (int k = 1; k <= 16; k++) begin
            cyc(0, ST_PLAY, 1, DIR_RIGHT, 1, 1);
            if (k == 16) check("wall_crash", crash, 1);
            cyc(0, (k == 16) ? ST_OVER : ST_PLAY, 0, DIR_RIGHT, 1, 1);
        end
        check("wall_x", head_x, 30);
        for (int k = 0; k < 3; k++) cyc(0, ST_OVER, 1, DIR_UP, 1, 1);
        check("over_hold_x", head_x, 30);
        check("over_hold_y", head_y, 11);
        q_at("query_head", 30, 11, 1);
        q_at("query_corner", 1, 1, 0);

        // Grow to MAX_LEN, then eat once more.
        cyc(0, ST_INIT, 0, DIR_RIGHT, 1, 1);
        for (int k = 1; k <= 14; k++) begin
            cyc(0, ST_PLAY, 1, DIR_RIGHT, 5'(START_X + k), 11);
            cyc(0, ST_PLAY, 0, DIR_RIGHT, 1, 1);
        end
        check("max_len", length, 16);
        check("max_x", head_x, 29);

        // Reset in the same cycle as a tick.
        cyc(1, ST_PLAY, 1, DIR_RIGHT, 30, 11);
        check("rst_mid_food", get_food, 0);
        check("rst_mid_x", head_x, 15);

        // Randomized play.
        st = ST_PLAY; rd = DIR_RIGHT; fx = 20; fy = 11;
        since_tick = 2; over_cnt = 0;
        for (int n = 0; n < 3000; n++) begin
            r = ($urandom_range(0, 299) == 0);
            t = (since_tick >= 2) && ($urandom_range(0, 2) == 0);
            since_tick = t ? 0 : since_tick + 1;
            if ($urandom_range(0, 3) == 0) rd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin
                fx = body[0][9:5];
                fy = body[0][4:0];
                if (m_cur == DIR_UP)         fy = fy - 5'd1;
                else if (m_cur == DIR_DOWN)  fy = fy + 5'd1;
                else if (m_cur == DIR_LEFT)  fx = fx - 5'd1;
                else                         fx = fx + 5'd1;
            end else if ($urandom_range(0, 3) == 0) begin
                fx = 5'($urandom_range(1, GRID_W - 2));
                fy = 5'($urandom_range(1, GRID_H - 2));
            end
            cyc(r, st, t, rd, fx, fy);
            if (st == ST_INIT) st = ST_PLAY;
            else if (e_crash) begin st = ST_OVER; over_cnt = 0; end
            else if (st == ST_OVER) begin
                over_cnt++;
                if (over_cnt > 3) st = ST_INIT;
            end
            else if (st == ST_PLAY && $urandom_range(0, 49) == 0) st = ST_PAUSE;
            else if (st == ST_PAUSE && $urandom_range(0, 3) == 0) st = ST_PLAY;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
